seq_pattern_tx: RTL and testbench

Serial pattern transmitter. It is the driving end for the 1001 Mealy sequence detector.
- On a start request it captures a PAT_W-bit pattern and a repeat count.
- It shifts the pattern out one bit per clock, LSB first, for repeat_n+1 frames, with optional idle gap cycles between frames.
- A hold input lets the consumer stall the stream.
- Used as the stimulus/test source for serial detectors and as a bit-stream generator in larger designs.

---
 rtl/seq_tx_pkg.sv | 15 +
 rtl/seq_piso_shreg.sv | 38 +++
 rtl/seq_pattern_tx.sv | 161 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   tx_state_e : FSM state encoding (2 bits, all four codes used)
//   PAT_1001   : default pattern matching the 1001 sequence detector
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } tx_state_e;

  localparam logic [3:0] PAT_1001 = 4'b1001;

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-in serial-out shift register holding the transmit datapath.
//   clk, rst : clock, synchronous active-high reset (clears contents)
//   load     : load din (has priority over shift)
//   shift    : advance by one bit toward the head
//   din      : parallel load value
//   head     : bit currently presented for transmission
// LSB_FIRST selects whether bit 0 or bit W-1 is the head.
module seq_piso_shreg #(
  parameter int W         = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         head
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      if (LSB_FIRST != 0) begin
        q <= {1'b0, q[W-1:1]};
      end else begin
        q <= {q[W-2:0], 1'b0};
      end
    end
  end

  assign head = (LSB_FIRST != 0) ? q[0] : q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter.
// Captures a PAT_W-bit pattern and repeat count on start (in IDLE) and
// shifts the pattern out one bit per clock for repeat_n+1 frames, with
// GAP_CYCLES idle cycles between frames. hold stalls bit/frame progress.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, only sampled in IDLE
//   pattern     : pattern captured on accepted start
//   repeat_n    : extra frames (total = repeat_n+1), captured on start
//   hold        : stall while high (SHIFT only)
//   out         : serial data bit (0 when not valid)
//   out_valid   : out carries a pattern bit this cycle
//   busy        : SHIFT or GAP
//   frame_start : valid bit is bit 0 of a frame
//   done        : one-cycle pulse after last bit of last frame
//   state_dbg   : current FSM state encoding
//
// Handshake: out_valid is a pure source-side valid; hold acts as an
// inverted ready. A bit is consumed on every posedge with out_valid=1,
// and out_valid already accounts for hold, so no bit is ever lost.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int PAT_W      = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int LSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             hold,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_start,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int BIT_W      = $clog2(PAT_W);
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

  tx_state_e        state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;

  logic             sh_load;
  logic             sh_shift;
  logic [PAT_W-1:0] sh_din;
  logic             sh_head;

  seq_piso_shreg #(
    .W         (PAT_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .head  (sh_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      frm_cnt_q <= '0;
      gap_cnt_q <= '0;
      pat_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      frm_cnt_q <= frm_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pat_q     <= pat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frm_cnt_d = frm_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_din    = pat_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          pat_d     = pattern;
          sh_din    = pattern;
          sh_load   = 1'b1;
          frm_cnt_d = repeat_n;
          bit_cnt_d = '0;
        end
      end

      ST_SHIFT: begin
        if (!hold) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (frm_cnt_q == '0) begin
              state_d  = ST_DONE;
              sh_shift = 1'b1;
            end else begin
              // Reload the next frame now so that with no gap the first
              // bit of the new frame follows without a bubble.
              frm_cnt_d = frm_cnt_q - 1'b1;
              sh_load   = 1'b1;
              if (GAP_CYCLES > 0) begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
              end
            end
          end else begin
            sh_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        // hold is deliberately not consulted: the gap length is fixed.
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_valid   = (state_q == ST_SHIFT) && !hold;
  assign out         = out_valid && sh_head;
  assign busy        = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign frame_start = out_valid && (bit_cnt_q == '0);
  assign done        = (state_q == ST_DONE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance without gaps, one with
// GAP_CYCLES=2, sharing stimulus. Per-cycle outputs are captured into bit
// vectors (bit i = i-th cycle after the start cycle) and compared against
// hand-computed constants. A 1001 Mealy detector model consumes the
// no-gap instance for the loopback scenario.
module tb_seq_pattern_tx;
  import seq_tx_pkg::*;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeat_n;
  logic       hold;

  logic       out0, out_valid0, busy0, frame_start0, done0;
  logic [1:0] state_dbg0;
  logic       out2, out_valid2, busy2, frame_start2, done2;
  logic [1:0] state_dbg2;

  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_CYCLES(0), .LSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
    .hold(hold), .out(out0), .out_valid(out_valid0), .busy(busy0),
    .frame_start(frame_start0), .done(done0), .state_dbg(state_dbg0)
  );

  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_CYCLES(2), .LSB_FIRST(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
    .hold(hold), .out(out2), .out_valid(out_valid2), .busy(busy2),
    .frame_start(frame_start2), .done(done2), .state_dbg(state_dbg2)
  );

  // 1001 Mealy detector model fed by dut0
  logic [1:0] det_st;
  logic       det_clr;
  logic       det_hit;
  assign det_hit = out_valid0 && out0 && (det_st == 2'd3);

  always @(posedge clk) begin
    if (rst || det_clr) begin
      det_st <= 2'd0;
    end else if (out_valid0) begin
      case (det_st)
        2'd0:    det_st <= out0 ? 2'd1 : 2'd0;
        2'd1:    det_st <= out0 ? 2'd1 : 2'd2;
        2'd2:    det_st <= out0 ? 2'd1 : 2'd3;
        default: det_st <= out0 ? 2'd1 : 2'd0;
      endcase
    end
  end

  int checks;
  int passes;

  logic [31:0] cv0, co0, cf0, cb0, cd0;
  logic [31:0] cv2, co2, cf2, cb2, cd2;
  logic [31:0] cdet;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] p, input logic [3:0] r);
    pattern  = p;
    repeat_n = r;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic capture(input int n, input logic [31:0] hold_m,
                         input logic [31:0] start_m, input logic [31:0] rst_m);
    cv0 = '0; co0 = '0; cf0 = '0; cb0 = '0; cd0 = '0;
    cv2 = '0; co2 = '0; cf2 = '0; cb2 = '0; cd2 = '0;
    cdet = '0;
    for (int i = 0; i < n; i++) begin
      hold  = hold_m[i];
      start = start_m[i];
      rst   = rst_m[i];
      #1;
      cv0[i] = out_valid0; co0[i] = out0; cf0[i] = frame_start0;
      cb0[i] = busy0;      cd0[i] = done0;
      cv2[i] = out_valid2; co2[i] = out2; cf2[i] = frame_start2;
      cb2[i] = busy2;      cd2[i] = done2;
      cdet[i] = det_hit;
      tick();
    end
    hold  = 1'b0;
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    pattern = PAT_1001;
    tick();
    tick();
    start = 1'b0;
    #1;
    checks++; if ({out0, out_valid0, busy0, frame_start0, done0} !== 5'b0)
      $display("FAIL reset_outs0: got %b want 00000", {out0, out_valid0, busy0, frame_start0, done0}); else passes++;
    checks++; if (state_dbg0 !== 2'b00)
      $display("FAIL reset_state0: got %b want 00", state_dbg0); else passes++;
    checks++; if ({out2, out_valid2, busy2, frame_start2, done2} !== 5'b0)
      $display("FAIL reset_outs2: got %b want 00000", {out2, out_valid2, busy2, frame_start2, done2}); else passes++;
    rst = 1'b0;
    tick();
    checks++; if (state_dbg0 !== 2'b00)
      $display("FAIL reset_idle_after: got %b want 00", state_dbg0); else passes++;
  endtask

  task automatic test_single_frame();
    do_start(4'b1001, 4'd0);
    capture(6, 32'h0, 32'h0, 32'h0);
    checks++; if (cv0 !== 32'h0F) $display("FAIL single_valid: got %h want %h", cv0, 32'h0F); else passes++;
    checks++; if (co0 !== 32'h09) $display("FAIL single_out: got %h want %h", co0, 32'h09); else passes++;
    checks++; if (cf0 !== 32'h01) $display("FAIL single_fstart: got %h want %h", cf0, 32'h01); else passes++;
    checks++; if (cb0 !== 32'h0F) $display("FAIL single_busy: got %h want %h", cb0, 32'h0F); else passes++;
    checks++; if (cd0 !== 32'h10) $display("FAIL single_done: got %h want %h", cd0, 32'h10); else passes++;
    checks++; if (co2 !== 32'h09) $display("FAIL single_out_gap: got %h want %h", co2, 32'h09); else passes++;
  endtask

  task automatic test_back_to_back();
    do_start(4'b1011, 4'd2);
    capture(18, 32'h0, 32'h0, 32'h0);
    checks++; if (cv0 !== 32'h0FFF) $display("FAIL b2b_valid: got %h want %h", cv0, 32'h0FFF); else passes++;
    checks++; if (co0 !== 32'h0BBB) $display("FAIL b2b_out: got %h want %h", co0, 32'h0BBB); else passes++;
    checks++; if (cf0 !== 32'h0111) $display("FAIL b2b_fstart: got %h want %h", cf0, 32'h0111); else passes++;
    checks++; if (cd0 !== 32'h1000) $display("FAIL b2b_done: got %h want %h", cd0, 32'h1000); else passes++;
    checks++; if (cv2 !== 32'hF3CF) $display("FAIL gap3_valid: got %h want %h", cv2, 32'hF3CF); else passes++;
    checks++; if (cd2 !== 32'h10000) $display("FAIL gap3_done: got %h want %h", cd2, 32'h10000); else passes++;
  endtask

  task automatic test_gap_stall();
    do_start(4'b0111, 4'd1);
    capture(16, 32'h001C, 32'h0, 32'h0);
    checks++; if (cv2 !== 32'h1E63) $display("FAIL stall_valid: got %h want %h", cv2, 32'h1E63); else passes++;
    checks++; if (co2 !== 32'h0E23) $display("FAIL stall_out: got %h want %h", co2, 32'h0E23); else passes++;
    checks++; if (cf2 !== 32'h0201) $display("FAIL stall_fstart: got %h want %h", cf2, 32'h0201); else passes++;
    checks++; if (cb2 !== 32'h1FFF) $display("FAIL stall_busy: got %h want %h", cb2, 32'h1FFF); else passes++;
    checks++; if (cd2 !== 32'h2000) $display("FAIL stall_done: got %h want %h", cd2, 32'h2000); else passes++;
    checks++; if (cv0 !== 32'h07E3) $display("FAIL stall_valid_nogap: got %h want %h", cv0, 32'h07E3); else passes++;
  endtask

  task automatic test_start_while_busy();
    do_start(4'b1001, 4'd0);
    pattern  = 4'b0110;
    repeat_n = 4'd3;
    capture(6, 32'h0, 32'h12, 32'h0);
    checks++; if (co0 !== 32'h09) $display("FAIL busy_start_out: got %h want %h", co0, 32'h09); else passes++;
    checks++; if (cv0 !== 32'h0F) $display("FAIL busy_start_valid: got %h want %h", cv0, 32'h0F); else passes++;
    checks++; if (cd0 !== 32'h10) $display("FAIL busy_start_done: got %h want %h", cd0, 32'h10); else passes++;
    do_start(4'b0110, 4'd0);
    capture(6, 32'h0, 32'h0, 32'h0);
    checks++; if (co0 !== 32'h06) $display("FAIL restart_out: got %h want %h", co0, 32'h06); else passes++;
    checks++; if (cv0 !== 32'h0F) $display("FAIL restart_valid: got %h want %h", cv0, 32'h0F); else passes++;
  endtask

  task automatic test_reset_mid();
    do_start(4'b1001, 4'd2);
    capture(12, 32'h0, 32'h0, 32'h40);
    checks++; if (cv0 !== 32'h7F) $display("FAIL rstmid_valid: got %h want %h", cv0, 32'h7F); else passes++;
    checks++; if (co0 !== 32'h19) $display("FAIL rstmid_out: got %h want %h", co0, 32'h19); else passes++;
    checks++; if (cb0 !== 32'h7F) $display("FAIL rstmid_busy: got %h want %h", cb0, 32'h7F); else passes++;
    checks++; if (cd0 !== 32'h0) $display("FAIL rstmid_done: got %h want %h", cd0, 32'h0); else passes++;
    checks++; if (cd2 !== 32'h0) $display("FAIL rstmid_done_gap: got %h want %h", cd2, 32'h0); else passes++;
    checks++; if (state_dbg2 !== 2'b00) $display("FAIL rstmid_state_gap: got %b want 00", state_dbg2); else passes++;
    do_start(4'b1001, 4'd0);
    capture(6, 32'h0, 32'h0, 32'h0);
    checks++; if (co0 !== 32'h09) $display("FAIL rstmid_fresh_out: got %h want %h", co0, 32'h09); else passes++;
    checks++; if (cd0 !== 32'h10) $display("FAIL rstmid_fresh_done: got %h want %h", cd0, 32'h10); else passes++;
  endtask

  task automatic test_loopback();
    det_clr = 1'b1;
    tick();
    det_clr = 1'b0;
    do_start(PAT_1001, 4'd1);
    capture(12, 32'h0, 32'h0, 32'h0);
    checks++; if (cdet !== 32'h88) $display("FAIL loop_detect: got %h want %h", cdet, 32'h88); else passes++;
    checks++; if (cd0 !== 32'h100) $display("FAIL loop_done: got %h want %h", cd0, 32'h100); else passes++;
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = 4'b0;
    repeat_n = 4'b0;
    hold     = 1'b0;
    det_clr  = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap_stall();
    test_start_while_busy();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
